reg_arbiter: RTL and testbench

REG_ARBITER -- requirements
Module: reg_arbiter

---
 rtl/reg_arbiter_if.sv | 31 +++
 rtl/reg_arbiter.sv | 147 ++++++++++++++
 tb/tb_reg_arbiter.sv | 288 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/reg_arbiter_if.sv
// Bus bundle between requesters and the shared-register arbiter.
// master = requester side, slave = arbiter side.
interface reg_arbiter_if #(
  parameter int W = 8,
  parameter int N = 4
);
  logic [N-1:0]   req;
  logic [N*W-1:0] din;
  logic [N-1:0]   gnt;
  logic [N-1:0]   ack;
  logic [W-1:0]   q;
  logic           busy;

  modport master (
    output req,
    output din,
    input  gnt,
    input  ack,
    input  q,
    input  busy
  );

  modport slave (
    input  req,
    input  din,
    output gnt,
    output ack,
    output q,
    output busy
  );
endinterface

// File: rtl/reg_arbiter.sv
// N-way arbiter guarding one shared W-bit register; each write locks it for HOLD cycles.
// Define REG_ARBITER_RR_EN for round-robin selection; default is fixed priority (lowest index).
module reg_arbiter #(
  parameter int W    = 8,
  parameter int N    = 4,   // 2..8
  parameter int HOLD = 2    // 0..15
) (
  input  logic         clk,
  input  logic         rst,
  reg_arbiter_if.slave bus
);

  localparam int IW = $clog2(N);
  localparam logic [3:0] HOLD_LOAD = (HOLD > 0) ? 4'(HOLD - 1) : 4'd0;

  typedef enum logic [1:0] {
    S_IDLE,
    S_GRANT,
    S_HOLD
  } state_t;

  state_t         state_q, state_d;
  logic [N-1:0]   gnt_q, gnt_d;
  logic [N-1:0]   ack_q, ack_d;
  logic [W-1:0]   q_q, q_d;
  logic [3:0]     cnt_q, cnt_d;
  logic [IW-1:0]  owner_q, owner_d;
`ifdef REG_ARBITER_RR_EN
  logic [IW-1:0]  ptr_q, ptr_d;
`endif

  logic [N-1:0]   elig;
  logic           win_valid;
  logic [IW-1:0]  win_idx;

  // A requester whose ack is on the bus right now has not yet dropped req;
  // masking it stops a second service of the same request when HOLD=0.
  assign elig = bus.req & ~ack_q;

  // NOTE: every variable written in an always_comb gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    win_valid = 1'b0;
    win_idx   = '0;
`ifdef REG_ARBITER_RR_EN
    // Walk offsets from far to near so the nearest eligible index after ptr wins.
    for (int k = N; k >= 1; k--) begin
      if (elig[(int'(ptr_q) + k) % N]) begin
        win_valid = 1'b1;
        win_idx   = IW'((int'(ptr_q) + k) % N);
      end
    end
`else
    for (int i = N - 1; i >= 0; i--) begin
      if (elig[i]) begin
        win_valid = 1'b1;
        win_idx   = IW'(i);
      end
    end
`endif
  end

  // State and datapath registers.
  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_IDLE;
      gnt_q   <= '0;
      ack_q   <= '0;
      q_q     <= '0;
      cnt_q   <= '0;
      owner_q <= '0;
`ifdef REG_ARBITER_RR_EN
      ptr_q   <= IW'(N - 1);
`endif
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      ack_q   <= ack_d;
      q_q     <= q_d;
      cnt_q   <= cnt_d;
      owner_q <= owner_d;
`ifdef REG_ARBITER_RR_EN
      ptr_q   <= ptr_d;
`endif
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:  if (win_valid) state_d = S_GRANT;
      S_GRANT: state_d = (HOLD == 0) ? S_IDLE : S_HOLD;
      S_HOLD:  if (cnt_q == 4'd0) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Output / datapath next values. ack defaults low so it is a single-cycle pulse.
  always_comb begin
    gnt_d   = gnt_q;
    ack_d   = '0;
    q_d     = q_q;
    cnt_d   = cnt_q;
    owner_d = owner_q;
`ifdef REG_ARBITER_RR_EN
    ptr_d   = ptr_q;
`endif
    unique case (state_q)
      S_IDLE: begin
        if (win_valid) begin
          gnt_d          = '0;
          gnt_d[win_idx] = 1'b1;
          owner_d        = win_idx;
`ifdef REG_ARBITER_RR_EN
          ptr_d          = win_idx;
`endif
        end
      end
      S_GRANT: begin
        // Only the owner's slice reaches q; other requesters' din is never looked at.
        q_d   = bus.din[int'(owner_q) * W +: W];
        ack_d = gnt_q;
        if (HOLD == 0) gnt_d = '0;
        else           cnt_d = HOLD_LOAD;
      end
      S_HOLD: begin
        if (cnt_q == 4'd0) gnt_d = '0;
        else               cnt_d = cnt_q - 4'd1;
      end
      default: begin
        gnt_d = '0;
      end
    endcase
  end

  assign bus.gnt  = gnt_q;
  assign bus.ack  = ack_q;
  assign bus.q    = q_q;
  assign bus.busy = (state_q != S_IDLE);

  a_gnt_onehot: assert property (@(posedge clk) disable iff (!rst) $onehot0(gnt_q));
  a_ack_onehot: assert property (@(posedge clk) disable iff (!rst) $onehot0(ack_q));
  a_ack_owner:  assert property (@(posedge clk) disable iff (!rst) (ack_q == '0) || ack_q[owner_q]);
  a_gnt_busy:   assert property (@(posedge clk) disable iff (!rst) (state_q == S_IDLE) == (gnt_q == '0));

endmodule

// File: tb/tb_reg_arbiter.sv
// Randomized bench for reg_arbiter against a transaction-timeline model (HOLD=2 and HOLD=0 instances).
// Honors REG_ARBITER_RR_EN the same way the design does.
module tb_reg_arbiter;
  localparam int W = 8;
  localparam int N = 4;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  reg_arbiter_if #(.W(W), .N(N)) bus_a ();
  reg_arbiter_if #(.W(W), .N(N)) bus_b ();

  reg_arbiter #(.W(W), .N(N), .HOLD(2)) dut_a (.clk(clk), .rst(rst), .bus(bus_a));
  reg_arbiter #(.W(W), .N(N), .HOLD(0)) dut_b (.clk(clk), .rst(rst), .bus(bus_b));

  logic [N-1:0]   req_v     = '0;
  logic [N*W-1:0] din_v     = '0;
  logic [N-1:0]   drop_next = '0;
  bit             sel_b     = 1'b0;

  assign bus_a.req = sel_b ? '0 : req_v;
  assign bus_a.din = din_v;
  assign bus_b.req = sel_b ? req_v : '0;
  assign bus_b.din = din_v;

  logic [N-1:0] obs_gnt, obs_ack;
  logic [W-1:0] obs_q;
  logic         obs_busy;
  assign obs_gnt  = sel_b ? bus_b.gnt  : bus_a.gnt;
  assign obs_ack  = sel_b ? bus_b.ack  : bus_a.ack;
  assign obs_q    = sel_b ? bus_b.q    : bus_a.q;
  assign obs_busy = sel_b ? bus_b.busy : bus_a.busy;

  // Model: each service is a timeline anchored at the grant edge start_e.
  int           hold_m, e, start_e, owner, last;
  bit           started;
  logic [W-1:0] q_m;
  logic [N-1:0] ack_m;
  int           n_cmp, n_bad;

  task automatic check(string tag, logic [31:0] obs, logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    started = 1'b0;
    q_m     = '0;
    ack_m   = '0;
    last    = N - 1;
  endtask

  function automatic int pick(logic [N-1:0] el);
`ifdef REG_ARBITER_RR_EN
    for (int k = 1; k <= N; k++)
      if (el[(last + k) % N]) return (last + k) % N;
`else
    for (int i = 0; i < N; i++)
      if (el[i]) return i;
`endif
    return 0;
  endfunction

  task automatic model_edge();
    logic [N-1:0] el, nack;
    if (!rst) begin
      model_reset();
      return;
    end
    e++;
    el   = req_v & ~ack_m;
    nack = '0;
    if (started && e == start_e + 1) begin
      q_m         = din_v[owner*W +: W];
      nack[owner] = 1'b1;
    end
    if ((!started || e >= start_e + hold_m + 2) && el != '0) begin
      owner   = pick(el);
      last    = owner;
      started = 1'b1;
      start_e = e;
    end
    ack_m = nack;
  endtask

  task automatic compare();
    logic [N-1:0] g;
    g = '0;
    if (started && e >= start_e && e <= start_e + hold_m) g[owner] = 1'b1;
    check("gnt", obs_gnt, g);
    check("ack", obs_ack, ack_m);
    check("q", obs_q, q_m);
    check("busy", obs_busy, g != '0);
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    compare();
  endtask

  task automatic random_stim();
    for (int i = 0; i < N; i++) begin
      if (req_v[i]) begin
        if (drop_next[i]) begin
          req_v[i] = 1'b0;
          drop_next[i] = 1'b0;
        end else if (ack_m[i]) begin
          if ($urandom_range(1) == 0) req_v[i] = 1'b0;
          else drop_next[i] = 1'b1;
        end else if ($urandom_range(40) == 0) begin
          req_v[i] = 1'b0;
        end
      end else if ($urandom_range(3) == 0) begin
        req_v[i] = 1'b1;
      end
    end
    for (int i = 0; i < N; i++) din_v[i*W +: W] = W'($urandom);
  endtask

  task automatic do_reset();
    rst = 1'b0;
    model_reset();
    req_v = '0;
    drop_next = '0;
    step();
    step();
    rst = 1'b1;
  endtask

  task automatic mid_reset(string tag);
    rst = 1'b0;
    model_reset();
    req_v = '0;
    drop_next = '0;
    #1;
    check({tag, "_gnt"}, obs_gnt, 0);
    check({tag, "_ack"}, obs_ack, 0);
    check({tag, "_q"}, obs_q, 0);
    check({tag, "_busy"}, obs_busy, 0);
    step();
    rst = 1'b1;
  endtask

  task automatic contention(logic [N-1:0] pattern);
    logic [N-1:0] exp_order [5];
    logic [N-1:0] pg;
    int seen, prev_e;
    for (int i = 0; i < 5; i++) begin
`ifdef REG_ARBITER_RR_EN
      exp_order[i] = N'(1) << (i % N);
`else
      exp_order[i] = N'(2);
`endif
    end
    do_reset();
    req_v  = pattern;
    pg     = '0;
    seen   = 0;
    prev_e = 0;
    for (int c = 0; c < 60 && seen < 5; c++) begin
      step();
      if (obs_gnt != '0 && pg == '0) begin
        check("order", obs_gnt, exp_order[seen]);
        if (seen > 0) check("period", e - prev_e, 4);
        prev_e = e;
        seen++;
      end
      pg = obs_gnt;
    end
    check("order_count", seen, 5);
    req_v = '0;
  endtask

  initial begin
    int acks;
    n_cmp  = 0;
    n_bad  = 0;
    hold_m = 2;
    e      = 0;
    model_reset();

    // Reset values held with no clock edge yet
    #2;
    check("rst_gnt", obs_gnt, 0);
    check("rst_ack", obs_ack, 0);
    check("rst_q", obs_q, 0);
    check("rst_busy", obs_busy, 0);
    step();
    step();
    rst = 1'b1;

    // Single request, HOLD=2
    req_v = N'(1);
    din_v[0 +: W] = 8'hA5;
    step();
    check("single_gnt", obs_gnt, 1);
    check("single_busy1", obs_busy, 1);
    step();
    check("single_q", obs_q, 8'hA5);
    check("single_ack", obs_ack, 1);
    req_v = '0;
    step();
    check("single_busy3", obs_busy, 1);
    step();
    check("single_busy4", obs_busy, 0);

    // Owner 2 writes while requester 0's din toggles
    req_v = N'(4);
    din_v[2*W +: W] = 8'h3C;
    step();
    check("noise_gnt", obs_gnt, 4);
    din_v[0 +: W] = ~din_v[0 +: W];
    step();
    check("noise_q", obs_q, 8'h3C);
    req_v = '0;
    din_v[0 +: W] = ~din_v[0 +: W];
    step();
    din_v[0 +: W] = 8'hFF;
    step();
    check("noise_q_hold", obs_q, 8'h3C);

    // Reset during HOLD after the write landed
    req_v = N'(2);
    din_v[1*W +: W] = 8'h5A;
    step();
    req_v = '0;
    step();
    check("mh_q_before", obs_q, 8'h5A);
    mid_reset("rst_hold");

    // Reset during GRANT: no ack and no write afterwards
    req_v = N'(8);
    din_v[3*W +: W] = 8'h77;
    step();
    mid_reset("rst_grant");
    step();
    check("abort_no_ack", obs_ack, 0);
    check("abort_no_q", obs_q, 0);

    for (int i = 0; i < 400; i++) begin
      random_stim();
      step();
    end

`ifdef REG_ARBITER_RR_EN
    contention(N'(4'b1111));
`else
    contention(N'(4'b0110));
`endif

    // HOLD=0 instance
    sel_b  = 1'b1;
    hold_m = 0;
    do_reset();
    req_v = N'(1);
    din_v[0 +: W] = 8'hC3;
    acks = 0;
    step();
    acks += int'(obs_ack[0]);
    check("h0_gnt", obs_gnt, 1);
    step();
    acks += int'(obs_ack[0]);
    check("h0_q", obs_q, 8'hC3);
    step();
    acks += int'(obs_ack[0]);
    check("h0_masked_gnt", obs_gnt, 0);
    req_v = '0;
    step();
    acks += int'(obs_ack[0]);
    check("h0_no_regrant", obs_gnt, 0);
    check("h0_ack_count", acks, 1);

    for (int i = 0; i < 400; i++) begin
      random_stim();
      step();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
